freq_div_monitor: RTL and testbench
===================================

Name: freq_div_monitor

Overview:
- Checks a divided clock against its expected ratio. Sits directly downstream of the odd-N frequency divider.
- Samples the divider output (clk_div_in) in the clk_in domain and measures period and high time in clk_in cycles.
- Declares lock after LOCK_CNT consecutive good periods; raises sticky period, duty and timeout error flags.
- Bring-up and self-check block for the divider; all logic is clocked by clk_in only.

Parameters:
- N, 9: expected division ratio (odd, >= 3).
- LOCK_CNT, 4: consecutive good measurements required to assert locked (>= 1).
- CW, $clog2(2*N+1): measurement counter/output width (derived; do not override).

Ports:
- clk_in  input  1  system clock; same clock that drives the divider.
- reset  input  1  asynchronous, active-high reset.
- clk_div_in  input  1  divided clock under test; treated as asynchronous data.
- enable  input  1  1 = monitor runs; 0 = return to IDLE.
- err_clr  input  1  single-cycle pulse; clears the sticky error flags.
- period  output  CW  last measured rise-to-rise period, in clk_in cycles.
- high_time  output  CW  last measured high time, in clk_in cycles sampled high.
- meas_valid  output  1  one-cycle pulse when period/high_time update.
- locked  output  1  divider output verified stable.
- err_period  output  1  sticky: a measured period != N.
- err_duty  output  1  sticky: high_time outside {(N-1)/2, (N+1)/2}.
- timeout  output  1  sticky: no rising edge within 2*N cycles while armed.

Behaviour:
- Reset (asynchronous assert): all outputs 0, all internal counters 0, FSM = IDLE.
- Input path: 3-flop chain s1 <= clk_div_in, s2 <= s1, s3 <= s2. rise = s2 & ~s3.
- meas_valid/period/high_time update on the clk_in posedge following a rise. This is the 3rd posedge at which clk_div_in is sampled high, counting the first such sample as 1.
- per_cnt: loads 1 on a rise cycle, otherwise increments; saturates at 2*N.
- hi_cnt: loads 1 on a rise cycle, otherwise adds s2.
- On a rise in MEASURE or LOCKED:
  - period <= per_cnt, high_time <= hi_cnt, meas_valid pulses.
  - Steady divider gives period = N.
- Measurement is "good" when period == N and high_time is (N-1)/2 or (N+1)/2. Both values are legal because of the divider's half-cycle phase.
- FSM states:
  - IDLE: counters held at 0, locked = 0. enable = 1 -> ARM.
  - ARM: first rise only starts the counters (no meas_valid) -> MEASURE.
  - MEASURE: good -> good_cnt++; when good_cnt reaches LOCK_CNT -> LOCKED, and locked rises with that meas_valid. Bad -> good_cnt = 0, stay.
  - LOCKED: good -> stay. Bad -> locked = 0, good_cnt = 0 -> MEASURE.
  - Any state except IDLE: per_cnt reaching 2*N without a rise -> timeout = 1, locked = 0, good_cnt = 0 -> ARM.
  - Any state: enable = 0 -> IDLE (next cycle). period/high_time hold their last values.
- Error flags are set on the meas_valid cycle of a bad measurement:
  - err_period set on period mismatch.
  - err_duty set on a duty violation.
  - Both set if both fail.
- err_clr clears err_period, err_duty and timeout. If an error is set in the same cycle, set wins.
- enable and err_clr are synchronous to clk_in; no synchronizer is required on them.

Test Plan:
- Reset, enable = 1, drive a true 50% N = 9 divider clock:
  - period = 9 and high_time in {4, 5} on every meas_valid.
  - locked rises at the 4th meas_valid (5th rise).
  - No error flags set.
- Locked, then stretch one period to 10 cycles:
  - That meas_valid shows period = 10.
  - err_period = 1, locked = 0.
  - Relock after 4 further good periods; err_period stays 1.
- Period 9 with high time 2:
  - err_duty = 1, err_period = 0, locked = 0.
  - err_clr pulse -> err_duty = 0.
- Hold clk_div_in low after lock:
  - timeout = 1 exactly 18 cycles after the last rise cycle.
  - locked = 0, FSM = ARM.
  - Resume clock -> first rise gives no meas_valid.
- err_clr asserted in the same cycle as a bad measurement -> the flag ends at 1.
- reset asserted mid-measurement (asynchronously, between clk_in edges) -> all outputs 0 immediately.
- enable = 0 while locked -> locked = 0 next cycle, period holds 9.

Source files
------------

// File: rtl/freq_div_monitor_if.sv
// Signal bundle between a divided-clock source and freq_div_monitor.
// The master drives the clock under test and the controls; the slave reports measurements.
interface freq_div_monitor_if #(
  parameter int CW = 5
);
  logic          clk_div_in;
  logic          enable;
  logic          err_clr;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          locked;
  logic          err_period;
  logic          err_duty;
  logic          timeout;

  modport master (
    output clk_div_in, enable, err_clr,
    input  period, high_time, meas_valid, locked, err_period, err_duty, timeout
  );

  modport slave (
    input  clk_div_in, enable, err_clr,
    output period, high_time, meas_valid, locked, err_period, err_duty, timeout
  );
endinterface

// File: rtl/freq_div_monitor.sv
// Measures period and high time of an odd-N divided clock in clk_in cycles,
// declares lock after LOCK_CNT consecutive good periods and keeps sticky error flags.
module freq_div_monitor #(
  parameter int N        = 9,
  parameter int LOCK_CNT = 4,
  parameter int CW       = $clog2(2*N+1)
) (
  input  logic              clk_in,
  input  logic              reset,
  freq_div_monitor_if.slave mon
);
  localparam int            GW        = $clog2(LOCK_CNT+1);
  localparam logic [CW-1:0] PER_OK    = CW'(N);
  localparam logic [CW-1:0] HI_LO     = CW'((N-1)/2);
  localparam logic [CW-1:0] HI_HI     = CW'((N+1)/2);
  localparam logic [CW-1:0] PER_MAX   = CW'(2*N);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT-1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;
  state_t state_q, state_d;

  logic          s1, s2, s3, rise;
  logic [CW-1:0] per_cnt, hi_cnt, period_q, high_time_q;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic          meas_valid_q, locked_q, locked_d;
  logic          err_period_q, err_duty_q, timeout_q;
  logic          do_meas, cnt_clr, set_to;
  logic          per_bad, duty_bad, meas_good;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= PER_MAX) ? PER_MAX : v + CW'(1);
  endfunction

  assign rise      = s2 & ~s3;
  assign per_bad   = (per_cnt != PER_OK);
  // Either neighbour of N/2 is legal because the divider toggles on both phases.
  assign duty_bad  = (hi_cnt != HI_LO) && (hi_cnt != HI_HI);
  assign meas_good = ~per_bad & ~duty_bad;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    locked_d   = locked_q;
    do_meas    = 1'b0;
    cnt_clr    = 1'b0;
    set_to     = 1'b0;
    if (!mon.enable) begin
      state_d    = IDLE;
      good_cnt_d = '0;
      locked_d   = 1'b0;
      cnt_clr    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_clr = 1'b1;
          state_d = ARM;
        end
        ARM: if (rise) state_d = MEASURE;
        MEASURE, LOCKED: if (rise) begin
          do_meas = 1'b1;
          if (!meas_good) begin
            good_cnt_d = '0;
            locked_d   = 1'b0;
            state_d    = MEASURE;
          end else if (state_q == MEASURE) begin
            if (good_cnt_q == GOOD_LAST) begin
              good_cnt_d = '0;
              locked_d   = 1'b1;
              state_d    = LOCKED;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      // A dead divider restarts the search from ARM with fresh counters.
      if (state_q != IDLE && !rise && per_cnt == PER_MAX) begin
        set_to     = 1'b1;
        locked_d   = 1'b0;
        good_cnt_d = '0;
        cnt_clr    = 1'b1;
        state_d    = ARM;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      state_q      <= IDLE;
      good_cnt_q   <= '0;
      locked_q     <= 1'b0;
      meas_valid_q <= 1'b0;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      err_period_q <= 1'b0;
      err_duty_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      // Synchronizer and edge-detect stage
      s1 <= mon.clk_div_in;
      s2 <= s1;
      s3 <= s2;
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      locked_q     <= locked_d;
      meas_valid_q <= do_meas;
      // Measurement counter stage
      if (cnt_clr) begin
        per_cnt <= '0;
        hi_cnt  <= '0;
      end else if (rise) begin
        per_cnt <= CW'(1);
        hi_cnt  <= CW'(1);
      end else begin
        per_cnt <= sat_inc(per_cnt);
        if (s2) hi_cnt <= sat_inc(hi_cnt);
      end
      // Result and sticky-flag stage; a set beats a simultaneous clear
      if (do_meas) begin
        period_q    <= per_cnt;
        high_time_q <= hi_cnt;
      end
      err_period_q <= (do_meas & per_bad)  | (err_period_q & ~mon.err_clr);
      err_duty_q   <= (do_meas & duty_bad) | (err_duty_q & ~mon.err_clr);
      timeout_q    <= set_to | (timeout_q & ~mon.err_clr);
    end
  end

  assign mon.period     = period_q;
  assign mon.high_time  = high_time_q;
  assign mon.meas_valid = meas_valid_q;
  assign mon.locked     = locked_q;
  assign mon.err_period = err_period_q;
  assign mon.err_duty   = err_duty_q;
  assign mon.timeout    = timeout_q;
endmodule

// File: tb/tb_freq_div_monitor.sv
// Directed bench for freq_div_monitor: table of divider periods with expected
// measurements, plus hand sequences for timeout, disable and asynchronous reset.
module tb_freq_div_monitor;
  localparam int N    = 9;
  localparam int LOCK = 4;
  localparam int CW   = $clog2(2*N+1);

  // One divider period (hi cycles high, lo cycles low). Expectations are checked
  // on the meas_valid slot of this period and describe the previous period.
  typedef struct {
    int hi;
    int lo;
    int clr_at;
    int mv;
    int per;
    int ht;
    int lk;
    int ep;
    int ed;
    int to;
  } row_t;

  logic clk_in = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  row_t tbl[$];

  freq_div_monitor_if #(.CW(CW)) mon ();

  freq_div_monitor #(.N(N), .LOCK_CNT(LOCK)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .mon    (mon)
  );

  always #5 clk_in = ~clk_in;

  function automatic row_t mk(input int hi, input int lo, input int clr_at, input int mv,
                              input int per, input int ht, input int lk, input int ep,
                              input int ed, input int to);
    row_t r;
    r.hi = hi; r.lo = lo; r.clr_at = clr_at; r.mv = mv; r.per = per;
    r.ht = ht; r.lk = lk; r.ep = ep; r.ed = ed; r.to = to;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic d);
    mon.clk_div_in = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_row(input row_t r, input string tag);
    int stray = 0;
    for (int s = 1; s <= r.hi + r.lo; s++) begin
      mon.err_clr = (s == r.clr_at);
      step(s <= r.hi);
      mon.err_clr = 1'b0;
      if (s == 3) begin
        chk({tag, ".meas_valid"}, int'(mon.meas_valid), r.mv);
        if (r.mv != 0) begin
          chk({tag, ".period"}, int'(mon.period), r.per);
          chk({tag, ".high_time"}, int'(mon.high_time), r.ht);
        end
        chk({tag, ".locked"}, int'(mon.locked), r.lk);
        chk({tag, ".err_period"}, int'(mon.err_period), r.ep);
        chk({tag, ".err_duty"}, int'(mon.err_duty), r.ed);
        chk({tag, ".timeout"}, int'(mon.timeout), r.to);
      end else if (mon.meas_valid) begin
        stray++;
      end
    end
    chk({tag, ".stray_mv"}, stray, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".period"}, int'(mon.period), 0);
    chk({tag, ".high_time"}, int'(mon.high_time), 0);
    chk({tag, ".meas_valid"}, int'(mon.meas_valid), 0);
    chk({tag, ".locked"}, int'(mon.locked), 0);
    chk({tag, ".err_period"}, int'(mon.err_period), 0);
    chk({tag, ".err_duty"}, int'(mon.err_duty), 0);
    chk({tag, ".timeout"}, int'(mon.timeout), 0);
  endtask

  initial begin
    int stray;
    reset          = 1'b1;
    mon.clk_div_in = 1'b0;
    mon.enable     = 1'b0;
    mon.err_clr    = 1'b0;

    //        hi lo clr mv per ht lk ep ed to
    tbl.push_back(mk(5, 4, 0, 0,  0, 0, 0, 0, 0, 0));  // 0: ARM, first rise only
    tbl.push_back(mk(4, 5, 0, 1,  9, 5, 0, 0, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 4, 0, 0, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 5, 0, 0, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 5, 1, 0, 0, 0));  // 4th meas_valid locks
    tbl.push_back(mk(5, 5, 0, 1,  9, 5, 1, 0, 0, 0));  // stretched period
    tbl.push_back(mk(5, 4, 0, 1, 10, 5, 0, 1, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 5, 0, 1, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 5, 0, 1, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 5, 0, 1, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 5, 1, 1, 0, 0));  // 10: relock, err_period sticky
    tbl.push_back(mk(2, 7, 1, 1,  9, 5, 1, 0, 0, 0));  // clear; short high time
    tbl.push_back(mk(5, 4, 0, 1,  9, 2, 0, 0, 1, 0));
    tbl.push_back(mk(5, 4, 1, 1,  9, 5, 0, 0, 0, 0));
    tbl.push_back(mk(2, 8, 0, 1,  9, 5, 0, 0, 0, 0));  // both period and duty bad
    tbl.push_back(mk(5, 4, 3, 1, 10, 2, 0, 1, 1, 0));  // clear collides with set
    tbl.push_back(mk(5, 4, 1, 1,  9, 5, 0, 0, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 5, 0, 0, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 5, 0, 0, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 5, 1, 0, 0, 0));  // 19: locked before timeout
    tbl.push_back(mk(5, 4, 0, 0,  0, 0, 0, 0, 0, 1));  // 20: resume, no meas_valid
    tbl.push_back(mk(5, 4, 1, 1,  9, 5, 0, 0, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 5, 0, 0, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 5, 0, 0, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1,  9, 5, 1, 0, 0, 0));  // 24: locked before disable
    tbl.push_back(mk(5, 4, 0, 0,  0, 0, 0, 0, 0, 0));  // 25: after re-enable
    tbl.push_back(mk(5, 5, 0, 1,  9, 5, 0, 0, 0, 0));
    tbl.push_back(mk(5, 4, 0, 1, 10, 5, 0, 1, 0, 0));

    repeat (2) @(posedge clk_in);
    #1;
    chk_all_zero("reset");

    reset      = 1'b0;
    mon.enable = 1'b1;
    repeat (3) step(1'b0);
    for (int i = 0; i < 20; i++) run_row(tbl[i], $sformatf("row%0d", i));

    // Row 19's meas_valid was step 3; hold low until step 21 (18 cycles later).
    stray = 0;
    for (int k = 0; k < 11; k++) begin
      step(1'b0);
      if (mon.meas_valid) stray++;
    end
    chk("timeout.early", int'(mon.timeout), 0);
    chk("timeout.locked_early", int'(mon.locked), 1);
    step(1'b0);
    chk("timeout.at18", int'(mon.timeout), 1);
    chk("timeout.locked", int'(mon.locked), 0);
    chk("timeout.stray_mv", stray, 0);

    for (int i = 20; i < 25; i++) run_row(tbl[i], $sformatf("row%0d", i));

    mon.enable = 1'b0;
    step(1'b1);
    chk("disable.locked", int'(mon.locked), 0);
    chk("disable.period", int'(mon.period), 9);
    chk("disable.high_time", int'(mon.high_time), 5);
    stray = 0;
    for (int k = 0; k < 9; k++) begin
      step(k < 5);
      if (mon.meas_valid) stray++;
    end
    chk("disable.period_hold", int'(mon.period), 9);
    chk("disable.stray_mv", stray, 0);

    mon.enable = 1'b1;
    step(1'b0);
    step(1'b0);
    for (int i = 25; i < 28; i++) run_row(tbl[i], $sformatf("row%0d", i));

    // Rise of the next period is in flight when reset hits between edges.
    step(1'b1);
    step(1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    reset = 1'b0;
    step(1'b1);
    chk("post_reset.period", int'(mon.period), 0);
    chk("post_reset.meas_valid", int'(mon.meas_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
